// File: rtl/audio_pkg.sv
// Shared audio definitions: PCM width, signed sample type, saturation
// limits, PDM front-end defaults and a 32-bit to PCM saturating helper.
package audio_pkg;

    localparam int unsigned PCM_W       = 16;
    localparam int unsigned AVG_W       = 24;
    localparam int unsigned CLK_DIV_DEF = 50;
    localparam int unsigned DECIM_DEF   = 64;

    typedef logic signed [PCM_W-1:0] pcm_t;

    localparam pcm_t PCM_MAX = 16'sh7FFF;
    localparam pcm_t PCM_MIN = 16'sh8000;

    // Clamp a wide signed value into the PCM range.
    function automatic pcm_t sat_pcm(input logic signed [31:0] x);
        if (x > 32'sd32767) begin
            return PCM_MAX;
        end
        if (x < -32'sd32768) begin
            return PCM_MIN;
        end
        return pcm_t'(x[PCM_W-1:0]);
    endfunction

endpackage

// File: rtl/pdm_mic_rx_if.sv
// PCM sample stream between the mic receiver and its consumer.
//   sample_data  : PCM sample (two's complement bits)
//   sample_valid : sample_data holds an unconsumed sample
//   sample_ready : consumer accepts the sample
interface pdm_mic_rx_if;
    import audio_pkg::*;

    logic [PCM_W-1:0] sample_data;
    logic             sample_valid;
    logic             sample_ready;

    modport master (output sample_data, output sample_valid, input sample_ready);
    modport slave  (input sample_data, input sample_valid, output sample_ready);

endinterface

// File: rtl/pdm_clk_gen.sv
// PDM microphone clock divider.
//   clk, rst_n : system clock, async active-low reset
//   enable     : run the divider; when low counter and m_clk are held at 0
//   m_clk      : microphone clock, f_clk/(2*CLK_DIV)
//   rise_c     : high in the cycle whose clock edge drives m_clk 0->1
//   fall_c     : high in the cycle whose clock edge drives m_clk 1->0
module pdm_clk_gen
    import audio_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic m_clk,
    output logic rise_c,
    output logic fall_c
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV);

    logic [CNT_W-1:0] cnt;
    logic             wrap_c;

    assign wrap_c = enable && (cnt == CNT_W'(CLK_DIV - 1));
    assign rise_c = wrap_c && !m_clk;
    assign fall_c = wrap_c && m_clk;

    // Half-period counter; m_clk toggles on wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            m_clk <= 1'b0;
        end else if (!enable) begin
            cnt   <= '0;
            m_clk <= 1'b0;
        end else if (wrap_c) begin
            cnt   <= '0;
            m_clk <= ~m_clk;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pdm_mic_rx.sv
// PDM microphone receiver: generates M_CLK, samples M_DATA on the selected
// edge, boxcar-decimates DECIM bits into signed 16-bit PCM delivered on a
// valid/ready stream, and reports peak |PCM| per LEVEL_WIN samples.
//   clk, rst_n      : system clock, async active-low reset
//   enable          : run mic clock and decimator
//   lr_sel          : channel select (0 = left/fall, 1 = right/rise)
//   M_CLK, M_LRSEL  : microphone clock and registered L/R select
//   M_DATA          : asynchronous PDM data
//   sample          : PCM stream (master side)
//   overflow        : sticky, an unconsumed sample was overwritten
//   ovf_clr         : clears overflow (a same-cycle set wins)
//   level           : peak |sample| of the last completed window
// Optional: define PDM_DC_BLOCK_EN to insert a first-order DC remover
// between the decimator and the output/level paths.
module pdm_mic_rx
    import audio_pkg::*;
#(
    parameter int unsigned CLK_DIV   = CLK_DIV_DEF,
    parameter int unsigned DECIM     = DECIM_DEF,
    parameter int unsigned LEVEL_WIN = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             lr_sel,
    output logic             M_CLK,
    output logic             M_LRSEL,
    input  logic             M_DATA,
    pdm_mic_rx_if.master     sample,
    output logic             overflow,
    input  logic             ovf_clr,
    output logic [PCM_W-1:0] level
);

    localparam int unsigned DW    = $clog2(DECIM);
    localparam int unsigned OW    = DW + 1;
    localparam int unsigned SHIFT = PCM_W - DW - 1;
    localparam int unsigned LW    = (LEVEL_WIN > 1) ? $clog2(LEVEL_WIN) : 1;

    logic             rise_c;
    logic             fall_c;
    logic [1:0]       sync;
    logic [DW-1:0]    bit_cnt;
    logic [OW-1:0]    ones;
    logic [LW-1:0]    win_cnt;
    logic [PCM_W-1:0] peak;

    logic               tick_c;
    logic               last_c;
    logic [OW-1:0]      ones_tot_c;
    logic signed [31:0] raw_c;
    pcm_t               pcm_c;
    pcm_t               out_c;
    logic [PCM_W-1:0]   abs_c;
    logic [PCM_W-1:0]   peak_max_c;
    logic               win_end_c;

    pdm_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .m_clk  (M_CLK),
        .rise_c (rise_c),
        .fall_c (fall_c)
    );

    // Two-flop synchronizer for the asynchronous PDM input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[0], M_DATA};
        end
    end

    // Capture edge follows the channel the mic was told to drive.
    assign tick_c = M_LRSEL ? rise_c : fall_c;
    assign last_c = tick_c && (bit_cnt == DW'(DECIM - 1));

    // Boxcar result including the bit captured this tick.
    always_comb begin
        ones_tot_c = ones + OW'(sync[1]);
        raw_c      = (signed'(32'(ones_tot_c)) <<< 1) - signed'(32'(DECIM));
        pcm_c      = sat_pcm(raw_c <<< SHIFT);
    end

`ifdef PDM_DC_BLOCK_EN
    logic signed [AVG_W-1:0] avg;
    logic signed [31:0]      diff_c;
    logic signed [31:0]      step_c;

    // avg is 16.8 fixed point; the same shifted difference is both the
    // integer output and the fractional tracking step.
    always_comb begin
        diff_c = (32'(pcm_c) <<< 8) - 32'(avg);
        step_c = diff_c >>> 8;
        out_c  = sat_pcm(step_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            avg <= '0;
        end else if (last_c) begin
            avg <= avg + AVG_W'(step_c);
        end
    end
`else
    assign out_c = pcm_c;
`endif

    // Magnitude with |0x8000| clamped to 0x7FFF.
    always_comb begin
        abs_c = out_c[PCM_W-1] ? PCM_W'(-out_c) : PCM_W'(out_c);
        if (out_c == PCM_MIN) begin
            abs_c = PCM_W'(PCM_MAX);
        end
        peak_max_c = (abs_c > peak) ? abs_c : peak;
        win_end_c  = (win_cnt == LW'(LEVEL_WIN - 1));
    end

    // Bit/ones counters; L/R select latched only while stopped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            ones    <= '0;
            M_LRSEL <= 1'b0;
        end else if (!enable) begin
            bit_cnt <= '0;
            ones    <= '0;
            M_LRSEL <= lr_sel;
        end else if (last_c) begin
            bit_cnt <= '0;
            ones    <= '0;
        end else if (tick_c) begin
            bit_cnt <= bit_cnt + DW'(1);
            ones    <= ones_tot_c;
        end
    end

    // Output register and handshake; a new sample always loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample.sample_data  <= '0;
            sample.sample_valid <= 1'b0;
        end else if (last_c) begin
            sample.sample_data  <= out_c;
            sample.sample_valid <= 1'b1;
        end else if (sample.sample_valid && sample.sample_ready) begin
            sample.sample_valid <= 1'b0;
        end
    end

    // Sticky overwrite flag; set has priority over clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (last_c && sample.sample_valid && !sample.sample_ready) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    // Peak tracker over produced samples, consumed or not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt <= '0;
            peak    <= '0;
            level   <= '0;
        end else if (last_c) begin
            if (win_end_c) begin
                win_cnt <= '0;
                peak    <= '0;
                level   <= peak_max_c;
            end else begin
                win_cnt <= win_cnt + LW'(1);
                peak    <= peak_max_c;
            end
        end
    end

endmodule

// File: tb/tb_pdm_mic_rx.sv
// Directed bench for pdm_mic_rx with CLK_DIV=2, DECIM=64, LEVEL_WIN=4.
// PDM bits are driven on the M_CLK edge opposite to the capture edge so
// each bit is stable through the synchronizer when it is captured.
module tb_pdm_mic_rx;
    import audio_pkg::*;

    localparam int unsigned CLK_DIV   = 2;
    localparam int unsigned DECIM     = 64;
    localparam int unsigned LEVEL_WIN = 4;

    localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] ALL0 = 64'h0000_0000_0000_0000;
    localparam logic [63:0] ALT  = 64'h5555_5555_5555_5555;
    localparam logic [63:0] P48  = 64'h0000_FFFF_FFFF_FFFF;
    localparam logic [63:0] P8   = 64'h0000_0000_0000_00FF;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b1;
    logic        enable  = 1'b0;
    logic        lr_sel  = 1'b0;
    logic        M_DATA  = 1'b0;
    logic        ovf_clr = 1'b0;
    logic        M_CLK;
    logic        M_LRSEL;
    logic        overflow;
    logic [15:0] level;

    int n_cmp = 0;
    int n_bad = 0;

    pdm_mic_rx_if sif ();

    pdm_mic_rx #(
        .CLK_DIV   (CLK_DIV),
        .DECIM     (DECIM),
        .LEVEL_WIN (LEVEL_WIN)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .lr_sel   (lr_sel),
        .M_CLK    (M_CLK),
        .M_LRSEL  (M_LRSEL),
        .M_DATA   (M_DATA),
        .sample   (sif),
        .overflow (overflow),
        .ovf_clr  (ovf_clr),
        .level    (level)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic cap_edge();
        if (lr_sel) @(posedge M_CLK);
        else        @(negedge M_CLK);
    endtask

    // Stop, select channel, preset the first bit, then run.
    task automatic start_run(input logic lr, input logic first_bit);
        @(negedge clk);
        enable = 1'b0;
        lr_sel = lr;
        M_DATA = first_bit;
        repeat (3) @(negedge clk);
        enable = 1'b1;
    endtask

    // Feed bits[0..63]; returns right at the final capture edge.
    task automatic send_window(input logic [63:0] bits, input logic rdy_last);
        M_DATA = bits[0];
        for (int i = 1; i < 64; i++) begin
            cap_edge();
            M_DATA = bits[i];
        end
        if (rdy_last) begin
            @(posedge M_CLK);
            @(posedge clk);
            sif.sample_ready = 1'b1;
        end
        cap_edge();
        if (rdy_last) sif.sample_ready = 1'b0;
    endtask

    task automatic win(input logic [63:0] bits, input string tag, input logic [15:0] exp);
        send_window(bits, 1'b0);
        @(negedge clk);
        check({tag, "_data"}, 32'(sif.sample_data), 32'(exp));
        check({tag, "_vld"}, 32'(sif.sample_valid), 32'd1);
        @(negedge clk);
        check({tag, "_pulse"}, 32'(sif.sample_valid), 32'd0);
    endtask

    task automatic reset_all();
        @(negedge clk);
        enable = 1'b0;
        rst_n  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        longint t0;
        longint t1;
        sif.sample_ready = 1'b1;

        // Reset values
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_mclk",  32'(M_CLK), 32'd0);
        check("rst_lrsel", 32'(M_LRSEL), 32'd0);
        check("rst_data",  32'(sif.sample_data), 32'd0);
        check("rst_vld",   32'(sif.sample_valid), 32'd0);
        check("rst_ovf",   32'(overflow), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        rst_n = 1'b1;

        // M_CLK period = 2*CLK_DIV clk cycles
        start_run(1'b0, 1'b0);
        @(posedge M_CLK);
        t0 = $time;
        @(posedge M_CLK);
        t1 = $time;
        check("mclk_period", 32'(t1 - t0), 32'd40);

        // Basic decimation values
        start_run(1'b0, 1'b1);
        win(ALL1, "all1", 16'h7FFF);
        win(ALL0, "all0", 16'h8000);
        win(ALT,  "alt",  16'h0000);
        win(P48,  "p48",  16'h4000);
        check("level_w0", 32'(level), 32'h7FFF);

        // Right channel captures on the rising edge
        start_run(1'b1, 1'b1);
        check("lrsel_reg", 32'(M_LRSEL), 32'd1);
        win(ALL1, "r_all1", 16'h7FFF);
        win(P48,  "r_p48",  16'h4000);

        // Reset mid-window with enable held high
        start_run(1'b0, 1'b1);
        win(ALL1, "pre_rst", 16'h7FFF);
        M_DATA = 1'b1;
        repeat (5) @(negedge M_CLK);
        @(posedge M_CLK);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_mclk",  32'(M_CLK), 32'd0);
        check("mid_rst_data",  32'(sif.sample_data), 32'd0);
        check("mid_rst_vld",   32'(sif.sample_valid), 32'd0);
        check("mid_rst_level", 32'(level), 32'd0);
        check("mid_rst_ovf",   32'(overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        win(P48, "post_rst", 16'h4000);

        // Overflow, clear, and transfer coinciding with a new sample
        sif.sample_ready = 1'b0;
        start_run(1'b0, 1'b1);
        send_window(ALL1, 1'b0);
        send_window(ALT, 1'b0);
        @(negedge clk);
        check("ovf_set",  32'(overflow), 32'd1);
        check("ovf_data", 32'(sif.sample_data), 32'h0000);
        check("ovf_vld",  32'(sif.sample_valid), 32'd1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("ovf_clr", 32'(overflow), 32'd0);
        start_run(1'b0, 1'b1);
        send_window(P48, 1'b1);
        @(negedge clk);
        check("xfer_ovf",  32'(overflow), 32'd0);
        check("xfer_vld",  32'(sif.sample_valid), 32'd1);
        check("xfer_data", 32'(sif.sample_data), 32'h4000);
        sif.sample_ready = 1'b1;

        // Peak level over LEVEL_WIN samples
        reset_all();
        start_run(1'b0, 1'b1);
        win(P48,  "lv0", 16'h4000);
        win(P8,   "lv1", 16'hA000);
        win(ALT,  "lv2", 16'h0000);
        check("level_pre", 32'(level), 32'd0);
        win(ALL0, "lv3", 16'h8000);
        check("level_pk", 32'(level), 32'h7FFF);
        win(ALT, "lz0", 16'h0000);
        win(ALT, "lz1", 16'h0000);
        win(ALT, "lz2", 16'h0000);
        check("level_hold", 32'(level), 32'h7FFF);
        win(ALT, "lz3", 16'h0000);
        check("level_zero", 32'(level), 32'd0);

        // Constant 48/64 input
        reset_all();
        start_run(1'b0, 1'b1);
`ifdef PDM_DC_BLOCK_EN
        repeat (40) send_window(P48, 1'b0);
        @(negedge clk);
        check("dc_decay",
              32'(($signed(sif.sample_data) < 16'sh4000) && ($signed(sif.sample_data) > 16'sh3000)),
              32'd1);
`else
        win(P48, "dc0", 16'h4000);
        win(P48, "dc1", 16'h4000);
        win(P48, "dc2", 16'h4000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pdm_mic_rx.md
Name: pdm_mic_rx

Overview:
- Microphone input path. It is the receive counterpart of the PWM audio output stage.
- Generates the PDM microphone clock and samples the 1-bit PDM stream.
- Decimates the stream with a boxcar count into signed 16-bit PCM samples, delivered over a valid/ready handshake.
- Also produces a peak level value. This value is sized to drive the 16-bit LED/PWM threshold of the output stage directly.

Parameters:
- CLK_DIV, 50, clk cycles per half period of M_CLK (min 2). M_CLK = f_clk/(2*CLK_DIV).
- DECIM, 64, PDM bits per PCM sample. Power of two, 8..256.
- LEVEL_WIN, 256, PCM samples per peak-level window. Power of two.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  run mic clock and decimator
- lr_sel  in  1  channel select, 0 = left, 1 = right
- M_CLK  out  1  microphone clock
- M_LRSEL  out  1  microphone L/R select, registered copy of lr_sel
- M_DATA  in  1  PDM data from microphone, asynchronous
- sample_data  out  16  signed PCM sample
- sample_valid  out  1  sample_data holds an unconsumed sample
- sample_ready  in  1  consumer accepts the sample
- overflow  out  1  sticky: an unconsumed sample was overwritten
- ovf_clr  in  1  clears overflow
- level  out  16  peak |sample| of the last completed window

Behaviour:
- Reset values:
  - M_CLK=0, M_LRSEL=0, sample_data=0, sample_valid=0, overflow=0, level=0.
  - All counters and accumulators are 0.
- Clock divider:
  - Counter runs 0..CLK_DIV-1. M_CLK toggles when the counter wraps.
  - While enable=0: counter and M_CLK are held at 0, and the bit counter and ones accumulator are cleared.
  - Held sample, sample_valid and level are retained while enable=0.
- Data capture:
  - M_DATA passes through a 2-flop synchronizer.
  - Capture tick for lr_sel=0: the cycle M_CLK is driven 1->0, i.e. the end of the high phase.
  - Capture tick for lr_sel=1: the cycle M_CLK is driven 0->1.
  - lr_sel is sampled into M_LRSEL only while enable=0.
- Decimation:
  - On each capture tick the ones counter increments if the synchronized bit is 1, and the bit counter increments.
  - On the DECIM-th bit: raw = 2*ones - DECIM, with range [-DECIM, +DECIM].
  - PCM = raw << (16 - log2(DECIM) - 1).
  - +32768 saturates to 0x7FFF. -DECIM maps to 0x8000.
  - Counters then restart at 0. The current bit is included in the completed window.
- Output handshake:
  - The new sample is registered into sample_data, and sample_valid=1 on the cycle after the final capture tick (latency 1).
  - A transfer occurs when sample_valid&&sample_ready. sample_valid clears the next cycle unless a new sample loads in the same cycle.
  - New sample arrives while sample_valid=1 and sample_ready=0: the sample is overwritten and overflow is set.
  - New sample arrives on the same cycle as a transfer: the new sample loads, sample_valid stays 1, overflow is unchanged.
  - ovf_clr and a set event on the same cycle: the set wins.
- Level:
  - Tracks the maximum of |PCM| over LEVEL_WIN produced samples, counted whether or not they are consumed.
  - |0x8000| saturates to 0x7FFF.
  - At window end the max is registered to level and the tracker restarts.
- Reset mid-operation: immediate return to reset values; M_CLK goes low asynchronously.

Optional Feature:
- Macro: PDM_DC_BLOCK_EN.
- Defined:
  - A first-order DC remover runs on PCM before output and level: y = x - avg, then avg <= avg + ((x - avg) >>> 8).
  - avg is a 24-bit register (16.8 fixed point). y saturates to 16 bits.
  - Latency is unchanged (combinational from x, avg registered).
- Undefined: PCM passes unmodified; no avg register exists.

Decomposition:
- Shared package audio_pkg holds:
  - the PCM width constant (16) and its signed sample type;
  - the saturation limits 0x7FFF/0x8000;
  - the defaults for CLK_DIV and DECIM.
- One sub-module, pdm_clk_gen, contains the divider, M_CLK and rise/fall tick outputs. Everything else stays in pdm_mic_rx.

Test Plan:
- Bench configuration: CLK_DIV=2, DECIM=64, sample_ready=1 unless stated.
- M_DATA constant 1 for 64 ticks -> sample_data=0x7FFF. Constant 0 -> 0x8000. Each has sample_valid pulse width 1.
- M_DATA alternating 1,0 -> sample_data=0x0000. 48 ones per 64 -> 0x4000.
- Check M_CLK period = 4 clk. lr_sel=1 captures on the rising edge. Assert rst_n=0 mid-window -> all outputs 0 in the same cycle, and the first sample after release covers a full 64 bits.
- sample_ready=0 over two windows -> overflow=1 and sample_data holds the second sample. ovf_clr pulse -> overflow=0. A transfer on the same cycle as a new sample -> no overflow.
- LEVEL_WIN=4, samples +0x4000, -0x6000, 0, 0x8000 -> level=0x7FFF after the 4th. Next window of all 0x0000 -> level=0.
- With PDM_DC_BLOCK_EN, constant 48/64 input -> output decays from 0x4000 toward 0 within 2048 samples. Without the macro -> output stays 0x4000.
